ps2_note_decoder: RTL and testbench
===================================

PS2_NOTE_DECODER -- requirements
Module: ps2_note_decoder

Interface
REQ-001 Parameter POLY, default 2: number of simultaneously held note slots, legal range 1..8.
REQ-002 Parameter NOTE_W, default 26: width of each period word, minimum 20.
REQ-003 Parameter FILT_LEN, default 4: number of consecutive equal synchronised ps2c samples needed to accept a level change.
REQ-004 Parameter TIMEOUT_CYC, default 100_000: number of CLK cycles without a ps2c falling edge that aborts a frame in progress.
REQ-005 Port CLK, input, 1: system clock; all logic is clocked on its rising edge.
REQ-006 Port RST_N, input, 1: reset, asynchronous, active-low.
REQ-007 Port ps2c, input, 1: raw PS/2 clock from the keyboard, asynchronous to CLK.
REQ-008 Port ps2d, input, 1: raw PS/2 data from the keyboard, asynchronous to CLK.
REQ-009 Port note_period, output, POLY*NOTE_W: slot i period occupies bits [i*NOTE_W +: NOTE_W]; value is 0 when the slot is free.
REQ-010 Port note_active, output, POLY: bit i is 1 while slot i holds a key.
REQ-011 Port key_code, output, 8: last accepted scan byte.
REQ-012 Port key_valid, output, 1: one-cycle pulse on each accepted byte.
REQ-013 Port frame_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-014 ps2c and ps2d shall each pass through a 2-flop synchroniser; ps2c shall then pass through the FILT_LEN glitch filter; a filtered 1->0 transition is the sample strobe.
REQ-015 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE->DATA on a strobe with ps2d=0 (start bit); a strobe with ps2d=1 shall keep the FSM in IDLE.
REQ-017 DATA shall shift in 8 bits LSB first, one per strobe, then go to PARITY.
REQ-018 PARITY shall capture 1 bit and go to STOP.
REQ-019 STOP shall accept the frame if the stop bit is 1 and odd parity holds over data+parity; otherwise it shall pulse frame_err and discard the byte. Either way the FSM returns to IDLE.
REQ-020 In any state other than IDLE, TIMEOUT_CYC cycles without a strobe shall force IDLE and pulse frame_err.
REQ-021 An accepted byte shall update key_code and pulse key_valid exactly 1 CLK cycle after the STOP strobe; slot updates shall occur in the same cycle.
REQ-022 Byte 0xF0 shall set the break flag; byte 0xE0 shall set the ext flag; neither byte touches any slot.
REQ-023 Both flags clear on the next non-prefix byte.
REQ-024 With ext=1, a byte shall produce no slot change (extended keys are unmapped).
REQ-025 Make byte: if period_lut(code)=0, or the code is already held (typematic repeat), or no slot is free, there shall be no slot change; otherwise the lowest-index free slot takes the code and its period.
REQ-026 No note stealing: when all slots are full, a new make is dropped.
REQ-027 Break byte (break flag set): the slot holding that code shall be freed (period 0, active 0); a break for a code not held is ignored.
REQ-028 Slots shall not compact; the remaining slots keep their indices.
REQ-029 period_lut shall map these 28 codes and return 0 for every other code:
  1A=95555, 22=85132, 21=75843, 2A=71586, 32=63776, 31=56818, 3A=50620;
  1C=190840, 1B=173611, 23=151515, 2B=142857, 34=127551, 33=113636, 3B=101239;
  15=382205, 1D=340507, 24=303361, 2D=286336, 2C=255102, 35=227273, 3C=202478;
  16=764526, 1E=681013, 26=606796, 25=572737, 2E=510204, 36=454545, 3D=404924.
  Each value is zero-extended to NOTE_W.

Reset
REQ-030 RST_N=0 shall asynchronously clear all outputs to 0, put the FSM in IDLE, clear the shift register, flags, slots and timeout counter, and preset the synchroniser and filter to 1 (bus idle).
REQ-031 Reset asserted mid-frame shall abandon the frame with no key_valid and no frame_err.
REQ-032 After release, the first frame is accepted normally.

Structure
REQ-033 Package ps2_note_pkg shall hold the scan-code constants (F0, E0), the FSM state enum and the period_lut function.
REQ-034 Sub-module ps2_frame_rx shall contain the synchroniser, filter, frame FSM and timeout, and output byte, byte_valid and frame_err.
REQ-035 The slot allocator shall reside in ps2_note_decoder.

Verification
REQ-036 Frame 0x1A with parity 0 and stop 1 -> key_valid, key_code=0x1A, slot0=95555, note_active=01.
REQ-037 Bytes F0, 1A after REQ-036 -> slot0=0, note_active=00.
REQ-038 POLY=2, makes 1A, 22, 21 -> slot0=95555, slot1=85132, 21 dropped; then break 1A and make 21 -> slot0=75843.
REQ-039 Frame 0x1A with parity 1 -> frame_err pulse, no key_valid, slots unchanged.
REQ-040 Start bit plus 3 data bits, then idle for TIMEOUT_CYC+1 cycles -> frame_err pulse, FSM in IDLE; a following valid frame with 0x22 -> slot0=85132.
REQ-041 RST_N pulsed low after bit 5 of a frame -> no pulses, outputs 0; next frame 0x16 -> slot0=764526.

Source files
------------

// File: rtl/ps2_note_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_note_pkg
// Purpose  : Shared scan-code constants, frame FSM state type and the
//            scan-code to note-period lookup table.
// Revision : 1.0  initial release
// ============================================================================
package ps2_note_pkg;

  // Prefix bytes of the PS/2 set-2 protocol
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Widest period value in the table fits in 20 bits
  localparam int LUT_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // Scan code to tone period in CLK cycles; 0 means the key is not a note
  function automatic logic [LUT_W-1:0] period_lut(input logic [7:0] code);
    logic [LUT_W-1:0] p;
    p = '0;
    case (code)
      8'h1A: p = 20'd95555;
      8'h22: p = 20'd85132;
      8'h21: p = 20'd75843;
      8'h2A: p = 20'd71586;
      8'h32: p = 20'd63776;
      8'h31: p = 20'd56818;
      8'h3A: p = 20'd50620;
      8'h1C: p = 20'd190840;
      8'h1B: p = 20'd173611;
      8'h23: p = 20'd151515;
      8'h2B: p = 20'd142857;
      8'h34: p = 20'd127551;
      8'h33: p = 20'd113636;
      8'h3B: p = 20'd101239;
      8'h15: p = 20'd382205;
      8'h1D: p = 20'd340507;
      8'h24: p = 20'd303361;
      8'h2D: p = 20'd286336;
      8'h2C: p = 20'd255102;
      8'h35: p = 20'd227273;
      8'h3C: p = 20'd202478;
      8'h16: p = 20'd764526;
      8'h1E: p = 20'd681013;
      8'h26: p = 20'd606796;
      8'h25: p = 20'd572737;
      8'h2E: p = 20'd510204;
      8'h36: p = 20'd454545;
      8'h3D: p = 20'd404924;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Purpose  : PS/2 receiver: input synchronisers, ps2c glitch filter,
//            11-bit frame FSM with odd-parity check and inactivity timeout.
//            byte_valid / frame_err are single-cycle strobes aligned with the
//            STOP sample; data_byte is meaningful while byte_valid is high.
// Revision : 1.0  initial release
// ============================================================================
module ps2_frame_rx
  import ps2_note_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic                c_meta, c_sync, d_meta, d_sync;
  logic [FILT_LEN-1:0] hist;
  logic                filt;
  logic                strobe;
  frame_state_t        state;
  logic [7:0]          shreg;
  logic [2:0]          bit_cnt;
  logic                par_bit;
  logic [CNT_W-1:0]    idle_cnt;
  logic                timeout;
  logic                frame_ok;

  // Two-flop synchronisers, preset to the idle-high bus level
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c;
      c_sync <= c_meta;
      d_meta <= ps2d;
      d_sync <= d_meta;
    end
  end

  // Filtered ps2c only flips after FILT_LEN identical samples
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= (hist << 1) | FILT_LEN'(c_sync);
      if (&hist && !filt) begin
        filt <= 1'b1;
      end else if (~|hist && filt) begin
        filt <= 1'b0;
      end
    end
  end

  // A filtered falling edge is the bit sample point
  assign strobe   = ~|hist && filt;
  assign timeout  = (state != ST_IDLE) && !strobe &&
                    (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign frame_ok = d_sync && (^{shreg, par_bit});

  assign data_byte  = shreg;
  assign byte_valid = strobe && (state == ST_STOP) && frame_ok;
  assign frame_err  = (strobe && (state == ST_STOP) && !frame_ok) || timeout;

  // Frame sequencer with per-bit inactivity watchdog
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      idle_cnt <= '0;
    end else if (strobe) begin
      idle_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (!d_sync) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shreg   <= {d_sync, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_bit <= d_sync;
          state   <= ST_STOP;
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end else if (state == ST_IDLE) begin
      idle_cnt <= '0;
    end else if (timeout) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_note_decoder
// Purpose  : Turns PS/2 key make/break codes into a set of POLY held-note
//            slots, each carrying the tone period of its key. Lowest free
//            slot wins, no stealing, no compaction.
// Revision : 1.0  initial release
// ============================================================================
module ps2_note_decoder
  import ps2_note_pkg::*;
#(
  parameter int POLY        = 2,
  parameter int NOTE_W      = 26,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   ps2c,
  input  logic                   ps2d,
  output logic [POLY*NOTE_W-1:0] note_period,
  output logic [POLY-1:0]        note_active,
  output logic [7:0]             key_code,
  output logic                   key_valid,
  output logic                   frame_err
);

  logic [7:0]        data_byte;
  logic              byte_valid;
  logic              rx_err;
  logic [NOTE_W-1:0] lut_val;
  logic              brk, ext;
  logic [7:0]        slot_code   [POLY];
  logic [NOTE_W-1:0] slot_period [POLY];
  logic [POLY-1:0]   slot_act;
  logic [POLY-1:0]   free_sel;
  logic [POLY-1:0]   held_sel;
  logic              taken;

  ps2_frame_rx #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .data_byte  (data_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_err)
  );

  assign lut_val     = NOTE_W'(period_lut(data_byte));
  assign note_active = slot_act;

  for (genvar i = 0; i < POLY; i++) begin : g_pack
    assign note_period[i*NOTE_W +: NOTE_W] = slot_period[i];
  end

  // One-hot lowest free slot, and mask of slots already holding the code
  always_comb begin
    free_sel = '0;
    held_sel = '0;
    taken    = 1'b0;
    for (int i = 0; i < POLY; i++) begin
      if (!slot_act[i] && !taken) begin
        free_sel[i] = 1'b1;
        taken       = 1'b1;
      end
      if (slot_act[i] && (slot_code[i] == data_byte)) begin
        held_sel[i] = 1'b1;
      end
    end
  end

  // Prefix tracking and slot allocate/free, all on the accepted-byte cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      slot_act  <= '0;
      for (int i = 0; i < POLY; i++) begin
        slot_code[i]   <= '0;
        slot_period[i] <= '0;
      end
    end else begin
      key_valid <= byte_valid;
      frame_err <= rx_err;
      if (byte_valid) begin
        key_code <= data_byte;
        if (data_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (data_byte == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          // Extended keys have no note mapping
          if (!ext) begin
            if (brk) begin
              for (int i = 0; i < POLY; i++) begin
                if (held_sel[i]) begin
                  slot_act[i]    <= 1'b0;
                  slot_code[i]   <= '0;
                  slot_period[i] <= '0;
                end
              end
            end else if ((lut_val != '0) && (held_sel == '0)) begin
              // Typematic repeats and full-slot makes fall through unchanged
              for (int i = 0; i < POLY; i++) begin
                if (free_sel[i]) begin
                  slot_act[i]    <= 1'b1;
                  slot_code[i]   <= data_byte;
                  slot_period[i] <= lut_val;
                end
              end
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_note_decoder
// Purpose  : Self-checking bench: directed scenarios followed by random
//            PS/2 frames, compared against a slot-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_note_decoder;

  localparam int POLY        = 2;
  localparam int NOTE_W      = 26;
  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 12;

  logic                   CLK   = 1'b0;
  logic                   RST_N = 1'b0;
  logic                   ps2c  = 1'b1;
  logic                   ps2d  = 1'b1;
  logic [POLY*NOTE_W-1:0] note_period;
  logic [POLY-1:0]        note_active;
  logic [7:0]             key_code;
  logic                   key_valid;
  logic                   frame_err;

  ps2_note_decoder #(
    .POLY        (POLY),
    .NOTE_W      (NOTE_W),
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .note_period (note_period),
    .note_active (note_active),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .frame_err   (frame_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  logic [POLY-1:0] act_at_kv = '0;

  // Pulse counters sampled mid-cycle
  always @(negedge CLK) begin
    if (key_valid) begin
      kv_cnt    = kv_cnt + 1;
      act_at_kv = note_active;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference note table
  logic [7:0] lut_code [28] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A,
                                8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
                                8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                                8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
  int lut_val [28] = '{95555, 85132, 75843, 71586, 63776, 56818, 50620,
                       190840, 173611, 151515, 142857, 127551, 113636, 101239,
                       382205, 340507, 303361, 286336, 255102, 227273, 202478,
                       764526, 681013, 606796, 572737, 510204, 454545, 404924};

  function automatic int ref_period(input logic [7:0] c);
    for (int i = 0; i < 28; i++) if (lut_code[i] == c) return lut_val[i];
    return 0;
  endfunction

  // Behavioural model: what each slot holds
  logic [7:0] m_code [POLY];
  int         m_per  [POLY];
  bit         m_act  [POLY];
  bit         m_brk, m_ext;
  logic [7:0] m_key;

  task automatic model_reset();
    for (int i = 0; i < POLY; i++) begin
      m_code[i] = 8'h00; m_per[i] = 0; m_act[i] = 1'b0;
    end
    m_brk = 1'b0; m_ext = 1'b0; m_key = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit held;
    int p;
    m_key = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext) begin
        if (m_brk) begin
          for (int i = 0; i < POLY; i++)
            if (m_act[i] && m_code[i] == b) begin
              m_act[i] = 1'b0; m_per[i] = 0; m_code[i] = 8'h00;
            end
        end else begin
          p = ref_period(b);
          held = 1'b0;
          for (int i = 0; i < POLY; i++) if (m_act[i] && m_code[i] == b) held = 1'b1;
          if (p != 0 && !held) begin
            for (int i = 0; i < POLY; i++)
              if (!m_act[i]) begin
                m_act[i] = 1'b1; m_per[i] = p; m_code[i] = b;
                break;
              end
          end
        end
      end
      m_brk = 1'b0; m_ext = 1'b0;
    end
  endtask

  function automatic logic [POLY-1:0] model_act_vec();
    logic [POLY-1:0] v;
    for (int i = 0; i < POLY; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive n bits LSB first, data set while clock high, sampled on fall
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      wait_cyc(HALF / 2);
      if (glitch) begin
        ps2c = 1'b0;
        wait_cyc($urandom_range(1, 2));
        ps2c = 1'b1;
      end
      wait_cyc(HALF / 2);
      ps2c = 1'b0;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
    logic par;
    logic stp;
    par = ~^b;
    stp = 1'b1;
    if (kind == 1) par = ~par;
    if (kind == 2) stp = 1'b0;
    return {stp, par, b, 1'b0};
  endfunction

  task automatic check_slots(input string tag);
    check({tag, ".active"}, 64'(note_active), 64'(model_act_vec()));
    for (int i = 0; i < POLY; i++)
      check($sformatf("%s.slot%0d", tag, i), 64'(note_period[i*NOTE_W +: NOTE_W]), 64'(m_per[i]));
  endtask

  task automatic do_frame(input logic [7:0] b, input int kind, input bit glitch, input string tag);
    int kv0, fe0;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(make_frame(b, kind), 11, glitch);
    wait_cyc(4);
    if (kind == 0) model_byte(b);
    check({tag, ".kv"}, 64'(kv_cnt - kv0), (kind == 0) ? 64'd1 : 64'd0);
    check({tag, ".fe"}, 64'(fe_cnt - fe0), (kind == 0) ? 64'd0 : 64'd1);
    check({tag, ".key"}, 64'(key_code), 64'(m_key));
    if (kind == 0) check({tag, ".act_at_kv"}, 64'(act_at_kv), 64'(model_act_vec()));
    check_slots(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".period"}, 64'(note_period), 64'd0);
    check({tag, ".active"}, 64'(note_active), 64'd0);
    check({tag, ".key"}, 64'(key_code), 64'd0);
    check({tag, ".kv"}, 64'(key_valid), 64'd0);
    check({tag, ".fe"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    int kv0, fe0, kind, sel;
    logic [7:0] b;

    model_reset();
    wait_cyc(5);
    check_all_zero("reset");
    RST_N = 1'b1;
    wait_cyc(5);
    check_all_zero("post_reset");

    // Single make, then release
    do_frame(8'h1A, 0, 1'b0, "make1a");
    check("make1a.slot0_abs", 64'(note_period[NOTE_W-1:0]), 64'd95555);
    check("make1a.active_abs", 64'(note_active), 64'd1);
    do_frame(8'hF0, 0, 1'b0, "brk_pfx");
    do_frame(8'h1A, 0, 1'b0, "brk1a");
    check("brk1a.active_abs", 64'(note_active), 64'd0);

    // Fill both slots, third make dropped, then reuse slot 0
    do_frame(8'h1A, 0, 1'b0, "fill_a");
    do_frame(8'h22, 0, 1'b0, "fill_b");
    do_frame(8'h21, 0, 1'b0, "drop_c");
    check("drop_c.slot1_abs", 64'(note_period[2*NOTE_W-1:NOTE_W]), 64'd85132);
    do_frame(8'h1A, 0, 1'b0, "typematic");
    do_frame(8'hF0, 0, 1'b0, "rel_pfx");
    do_frame(8'h1A, 0, 1'b0, "rel_a");
    do_frame(8'h21, 0, 1'b0, "reuse0");
    check("reuse0.slot0_abs", 64'(note_period[NOTE_W-1:0]), 64'd75843);

    // Bad parity and bad stop leave state alone
    do_frame(8'h1A, 1, 1'b0, "bad_par");
    do_frame(8'h2A, 2, 1'b0, "bad_stop");

    // Extended key is unmapped even if its code is a note
    do_frame(8'hE0, 0, 1'b0, "ext_pfx");
    do_frame(8'h2A, 0, 1'b0, "ext_key");

    // Clear slots before the timeout scenario
    do_frame(8'hF0, 0, 1'b0, "clr_p1");
    do_frame(8'h21, 0, 1'b0, "clr_1");
    do_frame(8'hF0, 0, 1'b0, "clr_p2");
    do_frame(8'h22, 0, 1'b0, "clr_2");

    // Partial frame then silence: watchdog must fire, but not early
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(make_frame(8'h55, 0), 4, 1'b0);
    wait_cyc(TIMEOUT_CYC - 30);
    check("timeout.early", 64'(fe_cnt - fe0), 64'd0);
    wait_cyc(50);
    check("timeout.fe", 64'(fe_cnt - fe0), 64'd1);
    check("timeout.kv", 64'(kv_cnt - kv0), 64'd0);
    do_frame(8'h22, 0, 1'b0, "after_to");
    check("after_to.slot0_abs", 64'(note_period[NOTE_W-1:0]), 64'd85132);

    // Reset in the middle of a frame, asserted between clock edges
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(make_frame(8'h3C, 0), 6, 1'b0);
    #2 RST_N = 1'b0;
    #1 check("async_rst.active", 64'(note_active), 64'd0);
    wait_cyc(3);
    check_all_zero("mid_rst");
    RST_N = 1'b1;
    model_reset();
    wait_cyc(5);
    check("mid_rst.kv", 64'(kv_cnt - kv0), 64'd0);
    check("mid_rst.fe", 64'(fe_cnt - fe0), 64'd0);
    do_frame(8'h16, 0, 1'b0, "after_rst");
    check("after_rst.slot0_abs", 64'(note_period[NOTE_W-1:0]), 64'd764526);

    // Random traffic with occasional glitches and corrupt frames
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 50)      b = lut_code[$urandom_range(0, 27)];
      else if (sel < 72) b = 8'hF0;
      else if (sel < 80) b = 8'hE0;
      else               b = 8'($urandom);
      kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      do_frame(b, kind, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      wait_cyc($urandom_range(0, 20));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
`default_nettype wire
